// File: rtl/hazard_unit_md.sv
// Hazard controller for the 5-stage RV32I pipeline: forwarding selects,
// load-use and branch flushes, and fixed-latency mul/div sequencing.
module hazard_unit_md #(
   parameter int MD_LAT = 4,
   parameter int CNT_W  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  Rs1D,
   input  logic [4:0]  Rs2D,
   input  logic [4:0]  Rs1E,
   input  logic [4:0]  Rs2E,
   input  logic [4:0]  RdE,
   input  logic [4:0]  RdM,
   input  logic [4:0]  RdW,
   input  logic        RegWriteM,
   input  logic        RegWriteW,
   input  logic        ResultSrcE0,
   input  logic        PCSrcE,
   input  logic        MulDivE,
   output logic        StallF,
   output logic        StallD,
   output logic        StallE,
   output logic        FlushD,
   output logic        FlushE,
   output logic        FlushM,
   output logic [1:0]  ForwardAE,
   output logic [1:0]  ForwardBE,
   output logic        MulDivDoneE,
   output logic [31:0] StallCycles
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             lw_stall;
   logic             md_stall;
   logic             md_done;

   function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
      if (RegWriteM && RdM != 5'd0 && RdM == rs)
         fwd_sel = 2'b10;
      else if (RegWriteW && RdW != 5'd0 && RdW == rs)
         fwd_sel = 2'b01;
      else
         fwd_sel = 2'b00;
   endfunction

   assign ForwardAE = fwd_sel(Rs1E);
   assign ForwardBE = fwd_sel(Rs2E);

   assign lw_stall = ResultSrcE0 && RdE != 5'd0
                     && (Rs1D == RdE || Rs2D == RdE);

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      md_stall = 1'b0;
      md_done  = 1'b0;
      unique case (state)
         IDLE: begin
            if (MulDivE) begin
               md_stall = 1'b1;
               state_nx = BUSY;
               cnt_nx   = CNT_W'(MD_LAT - 1);
            end
         end
         BUSY: begin
            cnt_nx = cnt - CNT_W'(1);
            if (cnt > CNT_W'(1)) begin
               md_stall = 1'b1;
            end else begin
               md_done  = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
      if (reset) begin
         state_nx = IDLE;
         cnt_nx   = '0;
      end
   end

   // Reset pins the pipeline open while flushing F/D and D/E.
   always_comb begin
      StallF      = 1'b0;
      StallD      = 1'b0;
      StallE      = 1'b0;
      FlushM      = 1'b0;
      MulDivDoneE = 1'b0;
      FlushD      = 1'b1;
      FlushE      = 1'b1;
      if (!reset) begin
         StallF      = lw_stall | md_stall;
         StallD      = lw_stall | md_stall;
         StallE      = md_stall;
         FlushM      = md_stall;
         MulDivDoneE = md_done;
         FlushD      = PCSrcE & ~md_stall;
         FlushE      = (lw_stall | PCSrcE) & ~md_stall;
      end
   end

   always_ff @(posedge clk) begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (reset)
         StallCycles <= 32'd0;
      else if (StallF)
         StallCycles <= StallCycles + 32'd1;
   end

endmodule

// File: doc/hazard_unit_md.md
Name: hazard_unit_md

Overview:
- Pipeline hazard controller for the 5-stage RV32I core.
- Drives the stall and flush controls consumed by the F/D, D/E and E/M pipeline registers, including the FlushE input of the D/E data register.
- Produces E-stage forwarding selects.
- Sequences a fixed-latency multi-cycle E-stage operation (mul/div) by holding F, D and E and injecting bubbles into M until the operation completes.

Parameters:
- MD_LAT, 4, cycles a multi-cycle op occupies E (legal range 2..16).
- CNT_W, 4, width of the internal busy counter (must satisfy 2^CNT_W > MD_LAT).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous reset, active high.
- Rs1D  in  5  source reg 1 index, Decode.
- Rs2D  in  5  source reg 2 index, Decode.
- Rs1E  in  5  source reg 1 index, Execute.
- Rs2E  in  5  source reg 2 index, Execute.
- RdE  in  5  dest reg index, Execute.
- RdM  in  5  dest reg index, Memory.
- RdW  in  5  dest reg index, Writeback.
- RegWriteM  in  1  Memory-stage instruction writes the register file.
- RegWriteW  in  1  Writeback-stage instruction writes the register file.
- ResultSrcE0  in  1  Execute-stage instruction is a load.
- PCSrcE  in  1  taken branch/jump resolved in Execute.
- MulDivE  in  1  Execute-stage instruction is a multi-cycle op.
- StallF  out  1  hold PC.
- StallD  out  1  hold F/D register.
- StallE  out  1  hold D/E register.
- FlushD  out  1  clear F/D register.
- FlushE  out  1  clear D/E register.
- FlushM  out  1  clear E/M register (bubble).
- ForwardAE  out  2  ALU operand A select: 00 RD1E, 01 ResultW, 10 ALUResultM.
- ForwardBE  out  2  ALU operand B select, same encoding as ForwardAE.
- MulDivDoneE  out  1  one-cycle pulse; multi-cycle result is valid in E this cycle.
- StallCycles  out  32  count of cycles with StallF=1.

Behaviour:
- State is IDLE or BUSY, plus busy counter cnt[CNT_W-1:0] and StallCycles.
- Reset (synchronous): next state IDLE, cnt=0, StallCycles=0.
- While reset is high, StallF, StallD, StallE, FlushM and MulDivDoneE are forced to 0 in the same cycle. FlushD and FlushE are forced to 1.
- Reset asserted mid-BUSY abandons the op. No MulDivDoneE pulse is produced for it.
- Forwarding (combinational, Rs1E for A and Rs2E for B):
  - 10 if RegWriteM & RdM!=0 & RdM==RsxE.
  - else 01 if RegWriteW & RdW!=0 & RdW==RsxE.
  - else 00.
  - M has priority over W. x0 is never forwarded.
- lwStall = ResultSrcE0 & RdE!=0 & (Rs1D==RdE | Rs2D==RdE).
- MdStall = (IDLE & MulDivE) | (BUSY & cnt>1).
- IDLE & MulDivE: next state BUSY, cnt<=MD_LAT-1.
- BUSY: cnt decrements each cycle.
  - At cnt==1: MulDivDoneE=1, MdStall=0, next state IDLE.
  - The E instruction therefore occupies E for exactly MD_LAT cycles, with MD_LAT-1 stall cycles.
  - MulDivE is ignored while BUSY.
- Back-to-back multi-cycle ops: the done cycle advances E. The next op starts from IDLE on the following cycle, with no lost or extra cycles.
- Output equations:
  - StallF = StallD = lwStall | MdStall.
  - StallE = MdStall.
  - FlushM = MdStall.
  - FlushE = (lwStall | PCSrcE) & ~MdStall.
  - FlushD = PCSrcE & ~MdStall.
- Priority: MdStall overrides load-use and branch flushes. A load and a taken branch in E with MulDivE are mutually exclusive by decode.
- PCSrcE & lwStall together: FlushD=1, FlushE=1, StallF=StallD=1. The flush discards the dependent instruction.
- StallCycles increments by 1 on each non-reset cycle with StallF=1. It wraps from 0xFFFFFFFF to 0.
- All outputs except state/cnt/StallCycles-derived terms are combinational from inputs and current state. Zero input-to-output latency.

Test Plan:
- Reset held 2 cycles with MulDivE=1 → StallF/D/E=0, FlushD=FlushE=1, StallCycles=0. The cycle after release, state is IDLE.
- RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5, Rs2E=0 → ForwardAE=10, ForwardBE=00. Then RegWriteM=0 → ForwardAE=01.
- ResultSrcE0=1, RdE=7, Rs2D=7 → StallF=StallD=FlushE=1 for one cycle, StallCycles+1. With RdE=0 instead → no stall.
- MD_LAT=4, MulDivE=1 for 4 cycles → StallF/D/E and FlushM =1,1,1,0 across those cycles. MulDivDoneE=0,0,0,1. StallCycles increases by 3.
- Two consecutive multi-cycle ops → two MulDivDoneE pulses exactly 4 cycles apart. PCSrcE=1 during BUSY → FlushD=FlushE=0.
- Reset asserted at cnt==2 during BUSY → no MulDivDoneE pulse, IDLE next cycle. A new MulDivE restarts a full 4-cycle sequence.
